onchip_ram_arbiter: RTL and testbench

- Shares the single-port 32-bit on-chip RAM (17-bit word address, 77500 words, 1-cycle read latency) between two Avalon-MM-style masters.
- Port A is the display scan-out reader (read-only, latency-critical). Port B is the CPU/drawing engine (read/write, byte-enabled).
- Issues at most one RAM access per cycle, with fixed A priority and a starvation guard for B.
- Returns read data to the owning port with a registered readdatavalid.

---
 rtl/onchip_ram_pkg.sv | 22 ++
 rtl/ram_rr_starve_ctr.sv | 37 +++
 rtl/onchip_ram_arbiter.sv | 118 +++++++++++
 tb/tb_onchip_ram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// rtl/onchip_ram_pkg.sv - shared constants and types for the on-chip RAM arbiter
// Contents: RAM geometry constants, read-owner enum, pending-read tag struct.
package onchip_ram_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 77500;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // One entry of the read-return pipeline: set on an accepted read,
  // consumed the following cycle when the RAM data arrives.
  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   oob;
  } rd_tag_t;

endpackage

// File: rtl/ram_rr_starve_ctr.sv
// rtl/ram_rr_starve_ctr.sv - consecutive port-A grant counter with starve flag
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   a_grant     : port A granted this cycle
//   b_grant     : port B granted this cycle
//   b_req       : port B has a request pending this cycle
//   starve      : B is pending and A has used up its streak; B must win
module ram_rr_starve_ctr #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic a_grant,
  input  logic b_grant,
  input  logic b_req,
  output logic starve
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] streak;

  // The streak only measures how long B has been waiting behind A, so it
  // restarts whenever B is served or stops asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= 8'd0;
    end else if (b_grant || !b_req) begin
      streak <= 8'd0;
    end else if (a_grant && (streak != LIMIT)) begin
      streak <= streak + 8'd1;
    end
  end

  assign starve = b_req && (streak == LIMIT);

endmodule

// File: rtl/onchip_ram_arbiter.sv
// rtl/onchip_ram_arbiter.sv - two-master arbiter for the single-port on-chip RAM
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   a_*                 : display scan-out read port (read-only, priority)
//   b_*                 : CPU / drawing engine port (read/write, byte-enabled)
//   ram_*               : single-port RAM, readdata valid one cycle after address
module onchip_ram_arbiter
#(
  parameter int ADDR_W       = onchip_ram_pkg::ADDR_W,
  parameter int DATA_W       = onchip_ram_pkg::DATA_W,
  parameter int DEPTH        = onchip_ram_pkg::DEPTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [DATA_W/8-1:0] b_byteenable,
  input  logic [DATA_W-1:0]   b_writedata,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  import onchip_ram_pkg::*;

  logic              b_req;
  logic              starve;
  logic              grant_a;
  logic              grant_b;
  logic [ADDR_W-1:0] sel_address;
  logic              sel_oob;
  logic              accept_read;
  rd_tag_t           tag;

  assign b_req = b_read | b_write;

  ram_rr_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .a_grant(grant_a),
    .b_grant(grant_b),
    .b_req  (b_req),
    .starve (starve)
  );

  // A wins unless B has waited out the streak limit.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = a_read && !starve;
      grant_b = b_req && !grant_a;
    end
  end

  assign a_waitrequest = !grant_a;
  assign b_waitrequest = !grant_b;

  assign sel_address = grant_b ? b_address : a_address;
  assign sel_oob     = (32'(sel_address) >= 32'(DEPTH));

  // Out-of-range accesses are still accepted so the master never hangs;
  // the RAM simply is not selected.
  assign ram_clken      = !reset;
  assign ram_address    = sel_address;
  assign ram_byteenable = grant_b ? b_byteenable : '1;
  assign ram_writedata  = grant_b ? b_writedata : '0;
  assign ram_chipselect = (grant_a || grant_b) && !sel_oob;
  assign ram_write      = grant_b && b_write && !sel_oob;

  // b_read with b_write counts as a write, so it produces no return data.
  assign accept_read = grant_a || (grant_b && !b_write);

  always_ff @(posedge clk) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag.valid <= accept_read;
      tag.owner <= grant_b ? OWN_B : OWN_A;
      tag.oob   <= sel_oob;
    end
  end

  // Gate with reset as well so a read accepted just before reset is never
  // reported in the first reset cycle.
  always_comb begin
    a_readdatavalid = 1'b0;
    b_readdatavalid = 1'b0;
    a_readdata      = '0;
    b_readdata      = '0;
    if (!reset && tag.valid) begin
      if (tag.owner == OWN_A) begin
        a_readdatavalid = 1'b1;
        a_readdata      = tag.oob ? '0 : ram_readdata;
      end else begin
        b_readdatavalid = 1'b1;
        b_readdata      = tag.oob ? '0 : ram_readdata;
      end
    end
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// tb/tb_onchip_ram_arbiter.sv - self-checking bench for onchip_ram_arbiter
// Ports: none; drives the arbiter and models the single-port RAM behind it.
module tb_onchip_ram_arbiter;

  localparam int DEPTH = 77500;

  logic        clk;
  logic        reset;
  logic [16:0] a_address;
  logic        a_read;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [16:0] b_address;
  logic        b_read;
  logic        b_write;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  logic [16:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata;

  int total;
  int bad;

  onchip_ram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .a_address      (a_address),
    .a_read         (a_read),
    .a_waitrequest  (a_waitrequest),
    .a_readdata     (a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address      (b_address),
    .b_read         (b_read),
    .b_write        (b_write),
    .b_byteenable   (b_byteenable),
    .b_writedata    (b_writedata),
    .b_waitrequest  (b_waitrequest),
    .b_readdata     (b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .ram_address    (ram_address),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model, one-cycle read latency.
  logic [31:0] mem [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC000_0000 | 32'(i);
    mem[5] = 32'hAAAA_AAAA;
    ram_readdata = 32'd0;
  end

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int k = 0; k < 4; k++)
          if (ram_byteenable[k]) mem[ram_address][k*8 +: 8] = ram_writedata[k*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    if (i == 5)   return 32'hAA22_AA44;
    if (i == 100) return 32'hDEAD_BEEF;
    return 32'hC000_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ar, input logic [16:0] aad,
                       input logic br, input logic bw, input logic [16:0] bad_addr,
                       input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    reset        = rst;
    a_read       = ar;
    a_address    = aad;
    b_read       = br;
    b_write      = bw;
    b_address    = bad_addr;
    b_byteenable = be;
    b_writedata  = wd;
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        ar;
    logic [16:0] aad;
    logic        br;
    logic        bw;
    logic [16:0] bad;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        xaw;
    logic        xbw;
    logic        xcs;
    logic        xwe;
    logic        xva;
    logic        xvb;
    logic [31:0] xra;
    logic [31:0] xrb;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic        prev_a;
    int          prev_addr;
    logic        ga;
    logic        gb;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_read = 1'b0; a_address = '0;
    b_read = 1'b0; b_write = 1'b0; b_address = '0;
    b_byteenable = 4'h0; b_writedata = 32'd0;

    //          rst   ar    aad        br    bw    bad          be       wd             xaw   xbw   xcs   xwe   xva   xvb   xra            xrb
    tbl[0]  = '{1'b1, 1'b1, 17'd0,     1'b0, 1'b1, 17'd200,   4'hF,    32'h12345678,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b0, 1'b1, 17'd0,     1'b0, 1'b1, 17'd200,   4'hF,    32'h12345678,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[4]  = '{1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 17'd5,     4'b0101, 32'h11223344,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hC0000000,  32'h0};
    tbl[5]  = '{1'b0, 1'b0, 17'd0,     1'b1, 1'b0, 17'd5,     4'hF,    32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 1'b0, 17'd0,     1'b0, 1'b0, 17'd0,     4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'hAA22AA44};
    tbl[7]  = '{1'b0, 1'b0, 17'd0,     1'b0, 1'b1, 17'd77500, 4'hF,    32'hFFFFFFFF,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[8]  = '{1'b0, 1'b0, 17'd0,     1'b1, 1'b0, 17'd77500, 4'hF,    32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[9]  = '{1'b0, 1'b0, 17'd0,     1'b0, 1'b0, 17'd0,     4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b0, 17'd0,     1'b1, 1'b0, 17'd77499, 4'hF,    32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0};
    tbl[11] = '{1'b0, 1'b1, 17'd7,     1'b0, 1'b0, 17'd0,     4'hF,    32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'hC0012EBB};
    tbl[12] = '{1'b0, 1'b0, 17'd0,     1'b1, 1'b0, 17'd8,     4'hF,    32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0000007,  32'h0};
    tbl[13] = '{1'b0, 1'b1, 17'd9,     1'b0, 1'b0, 17'd0,     4'hF,    32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         32'hC0000008};
    tbl[14] = '{1'b0, 1'b1, 17'd3,     1'b1, 1'b0, 17'd4,     4'hF,    32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hC0000009,  32'h0};
    tbl[15] = '{1'b0, 1'b0, 17'd0,     1'b0, 1'b0, 17'd0,     4'hF,    32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC0000003,  32'h0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].ar, tbl[i].aad, tbl[i].br, tbl[i].bw, tbl[i].bad, tbl[i].be, tbl[i].wd);
      chk($sformatf("v%0d a_wait", i), 32'(a_waitrequest), 32'(tbl[i].xaw));
      chk($sformatf("v%0d b_wait", i), 32'(b_waitrequest), 32'(tbl[i].xbw));
      chk($sformatf("v%0d cs", i), 32'(ram_chipselect), 32'(tbl[i].xcs));
      chk($sformatf("v%0d we", i), 32'(ram_write), 32'(tbl[i].xwe));
      chk($sformatf("v%0d a_rdv", i), 32'(a_readdatavalid), 32'(tbl[i].xva));
      chk($sformatf("v%0d b_rdv", i), 32'(b_readdatavalid), 32'(tbl[i].xvb));
      chk($sformatf("v%0d a_rd", i), a_readdata, tbl[i].xra);
      chk($sformatf("v%0d b_rd", i), b_readdata, tbl[i].xrb);
      if (tbl[i].rst) chk($sformatf("v%0d clken", i), 32'(ram_clken), 32'd0);
    end

    // A-only stream over addresses 0..9, then one idle cycle to drain.
    for (int k = 0; k <= 10; k++) begin
      drive(1'b0, k < 10, 17'(k), 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
      chk($sformatf("stream%0d a_wait", k), 32'(a_waitrequest), (k < 10) ? 32'd0 : 32'd1);
      chk($sformatf("stream%0d a_rdv", k), 32'(a_readdatavalid), (k > 0) ? 32'd1 : 32'd0);
      chk($sformatf("stream%0d a_rd", k), a_readdata, (k > 0) ? exp_word(k - 1) : 32'd0);
    end

    // Starvation guard: A streams, B holds a write until accepted.
    prev_a = 1'b0;
    prev_addr = 0;
    for (int c = 1; c <= 21; c++) begin
      drive(1'b0, c <= 20, 17'(20 + c), 1'b0, c <= 9, 17'd100, 4'hF, 32'hDEADBEEF);
      ga = (c <= 20) && (c != 9);
      gb = (c == 9);
      chk($sformatf("starve%0d a_wait", c), 32'(a_waitrequest), 32'(!ga));
      chk($sformatf("starve%0d b_wait", c), 32'(b_waitrequest), 32'(!gb));
      chk($sformatf("starve%0d we", c), 32'(ram_write), 32'(gb));
      chk($sformatf("starve%0d a_rdv", c), 32'(a_readdatavalid), 32'(prev_a));
      chk($sformatf("starve%0d a_rd", c), a_readdata, prev_a ? exp_word(prev_addr) : 32'd0);
      prev_a = ga;
      prev_addr = 20 + c;
    end

    drive(1'b0, 1'b1, 17'd100, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("rd100 a_wait", 32'(a_waitrequest), 32'd0);
    drive(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("rd100 a_rdv", 32'(a_readdatavalid), 32'd1);
    chk("rd100 a_rd", a_readdata, 32'hDEADBEEF);

    // Reset while a read is in flight: its data must never be reported.
    drive(1'b0, 1'b1, 17'd2, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("midrst accept", 32'(a_waitrequest), 32'd0);
    drive(1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("midrst rdv0", 32'(a_readdatavalid), 32'd0);
    chk("midrst rd0", a_readdata, 32'd0);
    drive(1'b1, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("midrst rdv1", 32'(a_readdatavalid), 32'd0);
    drive(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("midrst rdv2", 32'(a_readdatavalid), 32'd0);
    chk("midrst b_rdv2", 32'(b_readdatavalid), 32'd0);
    drive(1'b0, 1'b0, 17'd0, 1'b0, 1'b0, 17'd0, 4'hF, 32'h0);
    chk("midrst rdv3", 32'(a_readdatavalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
